// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame controller states and
// the frame geometry defaults also used by the miner work loader.
package uart_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2
    } uart_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT   = 8'h55;
    localparam int         FRAME_BYTES_DEFAULT = 44;

endpackage

// File: rtl/uart_frame_shadow.sv
// Shadow payload register: indexed byte-lane writes, a running XOR checksum
// over the written bytes, and the whole payload presented in parallel.
module uart_frame_shadow #(
    parameter int LANES = 44,
    parameter int IDX_W = $clog2(LANES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [7:0]         wr_byte,
    output logic [LANES*8-1:0] lanes,
    output logic [7:0]         xor_acc
);

    // Lanes are not cleared on a new frame: every lane is rewritten before
    // the shadow can ever be loaded into the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes   <= '0;
            xor_acc <= '0;
        end else if (clear) begin
            xor_acc <= '0;
        end else if (wr_en) begin
            xor_acc <= xor_acc ^ wr_byte;
            for (int i = 0; i < LANES; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    lanes[i*8 +: 8] <= wr_byte;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// Frame controller behind the UART receiver: sync hunt, payload collection,
// XOR checksum check and a held valid/ack output handshake.
//
// state   | meaning
// HUNT    | discarding bytes until SYNC_BYTE arrives
// COLLECT | writing payload bytes into the shadow lanes
// CHECK   | waiting for the checksum byte
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int         FRAME_BYTES = FRAME_BYTES_DEFAULT,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_data_ready,
    input  logic                     rx_error,
    input  logic                     rx_busy,
    output logic [FRAME_BYTES*8-1:0] frame_data,
    output logic                     frame_valid,
    input  logic                     frame_ack,
    output logic                     err_uart,
    output logic                     err_timeout,
    output logic                     err_checksum,
    output logic                     err_overrun
);

    localparam int               CNT_W    = $clog2(FRAME_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    uart_state_e state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic                     shadow_clear, shadow_wr;
    logic [FRAME_BYTES*8-1:0] shadow_lanes;
    logic [7:0]               shadow_xor;
    logic                     complete, load, valid_nxt;
    logic                     uart_nxt, timeout_nxt, checksum_nxt, overrun_nxt;

    uart_frame_shadow #(
        .LANES (FRAME_BYTES),
        .IDX_W (CNT_W)
    ) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .clear   (shadow_clear),
        .wr_en   (shadow_wr),
        .wr_idx  (cnt),
        .wr_byte (rx_byte),
        .lanes   (shadow_lanes),
        .xor_acc (shadow_xor)
    );

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        shadow_clear = 1'b0;
        shadow_wr    = 1'b0;
        complete     = 1'b0;
        uart_nxt     = 1'b0;
        timeout_nxt  = 1'b0;
        checksum_nxt = 1'b0;
        case (state)
            HUNT: begin
                if (rx_data_ready && rx_byte == SYNC_BYTE) begin
                    state_nxt    = COLLECT;
                    cnt_nxt      = '0;
                    shadow_clear = 1'b1;
                end
            end
            COLLECT: begin
                if (rx_error) begin
                    uart_nxt  = 1'b1;
                    state_nxt = HUNT;
                end else if (rx_data_ready) begin
                    shadow_wr = 1'b1;
                    cnt_nxt   = cnt + CNT_W'(1);
                    if (cnt == LAST_IDX) begin
                        state_nxt = CHECK;
                    end
                end else if (!rx_busy) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = HUNT;
                end
            end
            CHECK: begin
                if (rx_error) begin
                    uart_nxt  = 1'b1;
                    state_nxt = HUNT;
                end else if (rx_data_ready) begin
                    state_nxt = HUNT;
                    if (rx_byte == shadow_xor) begin
                        complete = 1'b1;
                    end else begin
                        checksum_nxt = 1'b1;
                    end
                end else if (!rx_busy) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = HUNT;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // A completion may replace a held frame only when it is acked that cycle.
    always_comb begin
        load        = complete && (!frame_valid || frame_ack);
        overrun_nxt = complete && frame_valid && !frame_ack;
        valid_nxt   = frame_valid;
        if (load) begin
            valid_nxt = 1'b1;
        end else if (frame_ack) begin
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HUNT;
            cnt          <= '0;
            frame_data   <= '0;
            frame_valid  <= 1'b0;
            err_uart     <= 1'b0;
            err_timeout  <= 1'b0;
            err_checksum <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            frame_valid  <= valid_nxt;
            err_uart     <= uart_nxt;
            err_timeout  <= timeout_nxt;
            err_checksum <= checksum_nxt;
            err_overrun  <= overrun_nxt;
            if (load) begin
                frame_data <= shadow_lanes;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer with a 4-byte payload: a queue-based frame model
// checked every cycle, plus literal expectations at key points.
module tb_uart_rx_framer;

    localparam int FB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_data_ready = 1'b0;
    logic          rx_error = 1'b0;
    logic          rx_busy = 1'b1;
    logic          frame_ack = 1'b0;
    logic [FB*8-1:0] frame_data;
    logic          frame_valid;
    logic          err_uart, err_timeout, err_checksum, err_overrun;

    int n_pass = 0;
    int n_total = 0;

    uart_rx_framer #(.FRAME_BYTES(FB), .SYNC_BYTE(8'h55)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_byte       (rx_byte),
        .rx_data_ready (rx_data_ready),
        .rx_error      (rx_error),
        .rx_busy       (rx_busy),
        .frame_data    (frame_data),
        .frame_valid   (frame_valid),
        .frame_ack     (frame_ack),
        .err_uart      (err_uart),
        .err_timeout   (err_timeout),
        .err_checksum  (err_checksum),
        .err_overrun   (err_overrun)
    );

    always #5 clk = ~clk;

    // Model: "in a frame" flag plus the list of payload bytes seen so far.
    bit          m_active;
    byte         m_q[$];
    logic [31:0] m_data;
    bit          m_valid, m_uart, m_to, m_chk, m_ovr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_q.delete(); m_data = '0; m_valid = 0;
            m_uart = 0; m_to = 0; m_chk = 0; m_ovr = 0;
        end else begin
            bit          comp;
            logic [7:0]  x;
            comp = 0;
            m_uart = 0; m_to = 0; m_chk = 0; m_ovr = 0;
            if (!m_active) begin
                if (rx_data_ready && rx_byte == 8'h55) begin
                    m_active = 1;
                    m_q.delete();
                end
            end else if (rx_error) begin
                m_uart = 1; m_active = 0;
            end else if (rx_data_ready) begin
                if (m_q.size() < FB) begin
                    m_q.push_back(rx_byte);
                end else begin
                    x = 8'h00;
                    foreach (m_q[i]) x = x ^ m_q[i];
                    m_active = 0;
                    if (rx_byte == x) comp = 1;
                    else m_chk = 1;
                end
            end else if (!rx_busy) begin
                m_to = 1; m_active = 0;
            end
            if (comp) begin
                if (!m_valid || frame_ack) begin
                    foreach (m_q[i]) m_data[i*8 +: 8] = m_q[i];
                    m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (frame_ack) begin
                m_valid = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("frame_valid", 32'(frame_valid), 32'(m_valid));
            chk("frame_data", frame_data, m_data);
            chk("err_uart", 32'(err_uart), 32'(m_uart));
            chk("err_timeout", 32'(err_timeout), 32'(m_to));
            chk("err_checksum", 32'(err_checksum), 32'(m_chk));
            chk("err_overrun", 32'(err_overrun), 32'(m_ovr));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte = b; rx_data_ready = 1'b1;
        cyc();
        rx_data_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, cs);
        send(8'h55); send(b0); send(b1); send(b2); send(b3); send(cs);
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        cyc();
        frame_ack = 1'b0;
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_data"}, frame_data, 32'h0);
        chk({tag, "_valid"}, 32'(frame_valid), 32'h0);
        chk({tag, "_errs"}, {28'h0, err_uart, err_timeout, err_checksum, err_overrun}, 32'h0);
    endtask

    initial begin
        cyc(); cyc();
        outputs_zero("reset");
        rst = 1'b0;
        cyc();

        // garbage then a good frame
        send(8'h00); send(8'hFF); send(8'h54);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        chk("good_valid", 32'(frame_valid), 32'h1);
        chk("good_data", frame_data, 32'h04030201);
        chk("model_good_data", m_data, 32'h04030201);
        ack();
        chk("ack_valid_low", 32'(frame_valid), 32'h0);
        ack();  // ack while idle is ignored

        // bad checksum, then a good frame
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
        chk("bad_cs_strobe", 32'(err_checksum), 32'h1);
        chk("bad_cs_valid", 32'(frame_valid), 32'h0);
        cyc();
        chk("bad_cs_one_clk", 32'(err_checksum), 32'h0);
        send_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h0C);
        chk("after_bad_data", frame_data, 32'h08070605);
        ack();

        // timeout abort, then fresh frame
        send(8'h55); send(8'hAA);
        rx_busy = 1'b0; cyc(); rx_busy = 1'b1;
        chk("timeout_strobe", 32'(err_timeout), 32'h1);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        chk("after_to_valid", 32'(frame_valid), 32'h1);
        ack();

        // uart error abort; error and idle in HUNT are ignored
        send(8'h55); send(8'hAA);
        rx_error = 1'b1; cyc(); rx_error = 1'b0;
        chk("uart_strobe", 32'(err_uart), 32'h1);
        rx_error = 1'b1; rx_busy = 1'b0; cyc(); rx_error = 1'b0; rx_busy = 1'b1;
        chk("hunt_ignores", {30'h0, err_uart, err_timeout}, 32'h0);

        // error beats a simultaneous byte; byte beats idle
        send(8'h55);
        rx_byte = 8'h11; rx_data_ready = 1'b1; rx_error = 1'b1;
        cyc(); rx_data_ready = 1'b0; rx_error = 1'b0;
        chk("err_over_byte", 32'(err_uart), 32'h1);
        send(8'h55); send(8'h10);
        rx_busy = 1'b0; send(8'h20); rx_busy = 1'b1;
        chk("byte_over_idle", 32'(err_timeout), 32'h0);
        send(8'h30); send(8'h40); send(8'h40);
        chk("idle_byte_frame", frame_data, 32'h40302010);

        // overrun: held frame kept
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        chk("overrun_strobe", 32'(err_overrun), 32'h1);
        chk("overrun_keeps", frame_data, 32'h40302010);
        // ack on completion cycle loads the new frame
        send(8'h55); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        frame_ack = 1'b1; send(8'h04); frame_ack = 1'b0;
        chk("ack_load_data", frame_data, 32'h04030201);
        chk("ack_load_valid", 32'(frame_valid), 32'h1);
        chk("ack_load_no_ovr", 32'(err_overrun), 32'h0);

        // async reset mid-frame with a frame held
        send(8'h55); send(8'h01); send(8'h02);
        #3 rst = 1'b1;
        #1 outputs_zero("async_rst");
        cyc();
        rst = 1'b0;
        send(8'h03); send(8'h04); send(8'h04);
        chk("post_rst_hunt", 32'(frame_valid), 32'h0);
        send_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4);
        chk("post_rst_frame", frame_data, 32'hD4C3B2A1);
        ack();
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Frame controller that sits directly behind the UART receiver and sequences its byte stream into fixed-length work packets for the miner core. It hunts for a sync byte, then collects a payload of FRAME_BYTES bytes and a trailing XOR checksum. It aborts on a receiver error or an inter-byte gap, and presents each good frame on a held valid/ack handshake.

## Interface
Parameters:
- FRAME_BYTES, 44, payload length in bytes; legal range 1..255.
- SYNC_BYTE, 8'h55, frame start marker.

Ports:
- clk  in  1  receiver communications clock.
- rst  in  1  asynchronous, active-high reset.
- rx_byte  in  8  byte from the UART receiver; valid when rx_data_ready is high.
- rx_data_ready  in  1  one-cycle strobe; a good byte has arrived.
- rx_error  in  1  one-cycle strobe; stop bit missing.
- rx_busy  in  1  low once the line has idled for 16 oversample ticks.
- frame_data  out  FRAME_BYTES*8  last accepted payload; byte 0 is in [7:0].
- frame_valid  out  1  frame_data holds an unacknowledged frame.
- frame_ack  in  1  consumer takes the frame.
- err_uart, err_timeout, err_checksum, err_overrun  out  1 each  one-cycle error strobes.

## Operation
- States: HUNT, COLLECT, CHECK. Reset state is HUNT.
- HUNT:
  - rx_data_ready with rx_byte==SYNC_BYTE: go to COLLECT, clear the byte counter and the XOR accumulator.
  - Any other byte is discarded silently.
- COLLECT:
  - Each rx_data_ready writes rx_byte into shadow lane [cnt], XORs it into the accumulator and increments cnt.
  - After lane FRAME_BYTES-1 is written, go to CHECK.
  - cnt width is $clog2(FRAME_BYTES+1). No wrap is possible.
- CHECK:
  - The next rx_data_ready compares rx_byte with the accumulator, then the block returns to HUNT.
  - Match: the frame completes (see handshake).
  - Mismatch: pulse err_checksum and discard the shadow.
- Abort (COLLECT or CHECK only):
  - rx_error: pulse err_uart, go to HUNT.
  - rx_busy low: pulse err_timeout, go to HUNT.
  - The shadow is discarded and frame_data is untouched.
  - rx_error and rx_busy low are both ignored in HUNT.
- Priority in one cycle: rx_error > rx_data_ready > rx_busy low. A byte strobe arriving together with an idle indication is consumed normally.
- Handshake:
  - On frame completion with frame_valid low, or with frame_ack high in the same cycle: copy the shadow to frame_data and hold frame_valid high.
  - On frame completion with frame_valid high and frame_ack low: drop the new frame, keep the old one, pulse err_overrun.
  - frame_ack with frame_valid high and no completion in that cycle: frame_valid falls next cycle.
  - frame_ack while frame_valid is low is ignored.
- frame_data changes only on a completion load. It is stable while frame_valid is high.

## Timing
- Reset values: frame_data 0, frame_valid 0, all err_* 0, state HUNT, cnt 0, accumulator 0.
- An asynchronous reset mid-frame discards any partial frame immediately.
- Completion latency: frame_valid rises 1 clk after the checksum byte's rx_data_ready.
- Error strobes assert 1 clk after the cause and last exactly 1 clk.
- State and counter update on the same edge that registers the strobe outputs.
- Ack: frame_valid falls on the clk edge after frame_ack is sampled high.
- Back-to-back frames: a SYNC_BYTE arriving on the cycle after a CHECK byte is accepted. There is no dead cycle.

## Structure
- Shared package uart_pkg:
  - state enumeration (HUNT, COLLECT, CHECK);
  - SYNC_BYTE default constant;
  - FRAME_BYTES default constant, shared with the miner work loader.
- One sub-module, uart_frame_shadow: FRAME_BYTES×8 lane register with indexed write, running XOR, and a parallel output. The FSM, counter and handshake live in the top.
- Everything is clocked on the single clk. No clock-domain crossing.

## Test plan
All scenarios use FRAME_BYTES=4.
- Good frame: bytes 55,01,02,03,04,04 → frame_data=32'h04030201 and frame_valid high 1 clk after the last strobe; no err_*.
- Bad checksum: 55,01,02,03,04,00 → err_checksum pulses once, frame_valid stays low, next good frame is accepted.
- Abort on gap and error:
  - 55,AA, then rx_busy low → err_timeout.
  - 55,AA, then rx_error → err_uart.
  - Both cases return to HUNT; the following 55 starts a fresh frame.
- Overrun and simultaneous ack:
  - Two good frames, no ack → err_overrun, frame_data holds the first.
  - Repeat with frame_ack on the completion cycle → second frame loads, frame_valid stays high, no err_overrun.
- Hunt and reset:
  - Garbage bytes 00,FF,54 before 55 → ignored.
  - rst asserted after 2 payload bytes → all outputs 0 asynchronously, state HUNT.
